// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states, ALU/bus select codes and NZVC indices for the 8-bit CPU (S_HALT only with CONTROL_UNIT_ILLEGAL_TRAP_EN)
package cpu_pkg;

  // Opcodes
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BPL     = 8'h22;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_BVC     = 8'h26;
  localparam logic [7:0] OP_BCS     = 8'h27;
  localparam logic [7:0] OP_BCC     = 8'h28;
  localparam logic [7:0] OP_ADD     = 8'h42;
  localparam logic [7:0] OP_SUB     = 8'h43;
  localparam logic [7:0] OP_AND     = 8'h44;
  localparam logic [7:0] OP_OR      = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_INCB    = 8'h47;
  localparam logic [7:0] OP_DECA    = 8'h48;
  localparam logic [7:0] OP_DECB    = 8'h49;
  localparam logic [7:0] OP_XOR     = 8'h4A;
  localparam logic [7:0] OP_NOTA    = 8'h4B;
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;

  // ALU_Sel codes, shared with the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_INC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  // Bus select encodings
  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_A    = 2'b01;
  localparam logic [1:0] BUS1_B    = 2'b10;
  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  // NZVC bit positions inside CCR_Result
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  // FSM states
  typedef logic [3:0] state_t;
  localparam state_t S_RST  = 4'd0;
  localparam state_t S_F0   = 4'd1;
  localparam state_t S_F1   = 4'd2;
  localparam state_t S_F2   = 4'd3;
  localparam state_t S_D3   = 4'd4;
  localparam state_t S_E4   = 4'd5;
  localparam state_t S_E5   = 4'd6;
  localparam state_t S_E6   = 4'd7;
  localparam state_t S_E7   = 4'd8;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  localparam state_t S_HALT = 4'd9;
`endif

  // Instruction classes; each class shares one execute micro-sequence
  typedef enum logic [2:0] {
    CLS_NONE, CLS_LD_IMM, CLS_LD_DIR, CLS_STORE, CLS_ALU, CLS_BRANCH
  } op_class_t;

  function automatic op_class_t op_class(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDB_IMM: op_class = CLS_LD_IMM;
      OP_LDA_DIR, OP_LDB_DIR: op_class = CLS_LD_DIR;
      OP_STA_DIR, OP_STB_DIR: op_class = CLS_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INCA, OP_INCB,
      OP_DECA, OP_DECB, OP_XOR, OP_NOTA: op_class = CLS_ALU;
      OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
      OP_BVS, OP_BVC, OP_BCS, OP_BCC: op_class = CLS_BRANCH;
      default: op_class = CLS_NONE;
    endcase
  endfunction

  function automatic logic [2:0] alu_sel_of(input logic [7:0] op);
    case (op)
      OP_SUB:           alu_sel_of = ALU_SUB;
      OP_AND:           alu_sel_of = ALU_AND;
      OP_OR:            alu_sel_of = ALU_OR;
      OP_INCA, OP_INCB: alu_sel_of = ALU_INC;
      OP_DECA, OP_DECB: alu_sel_of = ALU_DEC;
      OP_XOR:           alu_sel_of = ALU_XOR;
      OP_NOTA:          alu_sel_of = ALU_NOT;
      default:          alu_sel_of = ALU_ADD;
    endcase
  endfunction

  // Register B is the source/destination rather than A
  function automatic logic uses_b(input logic [7:0] op);
    case (op)
      OP_LDB_IMM, OP_LDB_DIR, OP_STB_DIR, OP_INCB, OP_DECB: uses_b = 1'b1;
      default: uses_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - resolves the branch condition of IR against NZVC flags
module branch_cond
  import cpu_pkg::*;
(
  input  logic [7:0] i_ir,
  input  logic [3:0] i_ccr,
  output logic       o_take
);

  // Select the flag (or its inverse) named by the branch opcode
  always_comb begin
    o_take = 1'b0;
    case (i_ir)
      OP_BRA:  o_take = 1'b1;
      OP_BMI:  o_take = i_ccr[CCR_N];
      OP_BPL:  o_take = ~i_ccr[CCR_N];
      OP_BEQ:  o_take = i_ccr[CCR_Z];
      OP_BNE:  o_take = ~i_ccr[CCR_Z];
      OP_BVS:  o_take = i_ccr[CCR_V];
      OP_BVC:  o_take = ~i_ccr[CCR_V];
      OP_BCS:  o_take = i_ccr[CCR_C];
      OP_BCC:  o_take = ~i_ccr[CCR_C];
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle Moore control FSM for the 8-bit CPU; CONTROL_UNIT_ILLEGAL_TRAP_EN traps unknown opcodes in S_HALT
module control_unit
  import cpu_pkg::*;
#(
  parameter int RST_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic [2:0] ALU_Sel,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write,
  output logic       Halted
);

  localparam logic [1:0] LP_RST_LAST = 2'(RST_CYCLES - 1);

  state_t    r_state;
  state_t    w_next;
  logic [1:0] r_rst_cnt;
  logic      r_take;
  logic      w_take;
  op_class_t w_class;
  logic      w_use_b;

  assign w_class = op_class(IR);
  assign w_use_b = uses_b(IR);

  branch_cond u_branch_cond (
    .i_ir   (IR),
    .i_ccr  (CCR_Result),
    .o_take (w_take)
  );

  // State register, post-reset idle counter and branch decision latched in D3
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RST;
      r_rst_cnt <= 2'd0;
      r_take    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RST) r_rst_cnt <= r_rst_cnt + 2'd1;
      if (r_state == S_D3)  r_take    <= w_take;
    end
  end

  // Next-state sequencing; execute length depends on the instruction class
  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST: w_next = (r_rst_cnt == LP_RST_LAST) ? S_F0 : S_RST;
      S_F0:  w_next = S_F1;
      S_F1:  w_next = S_F2;
      S_F2:  w_next = S_D3;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      S_D3:  w_next = (w_class == CLS_NONE) ? S_HALT : S_E4;
      S_HALT: w_next = S_HALT;
`else
      S_D3:  w_next = (w_class == CLS_NONE) ? S_F0 : S_E4;
`endif
      S_E4: begin
        case (w_class)
          CLS_LD_IMM, CLS_LD_DIR, CLS_STORE: w_next = S_E5;
          CLS_BRANCH: w_next = r_take ? S_E5 : S_F0;
          default:    w_next = S_F0;
        endcase
      end
      S_E5:  w_next = S_E6;
      S_E6:  w_next = (w_class == CLS_LD_DIR || w_class == CLS_STORE) ? S_E7 : S_F0;
      S_E7:  w_next = S_F0;
      default: w_next = S_RST;
    endcase
  end

  // Moore output decode from state and IR only; CCR enters solely via r_take
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    ALU_Sel  = ALU_ADD;
    CCR_Load = 1'b0;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    write    = 1'b0;
    case (r_state)
      S_F0: begin
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_BUS1;
        MAR_Load = 1'b1;
      end
      S_F1: PC_Inc = 1'b1;
      S_F2: begin
        Bus2_Sel = BUS2_MEM;
        IR_Load  = 1'b1;
      end
      S_E4: begin
        case (w_class)
          CLS_LD_IMM, CLS_LD_DIR, CLS_STORE: begin
            Bus2_Sel = BUS2_BUS1;
            MAR_Load = 1'b1;
          end
          CLS_ALU: begin
            ALU_Sel  = alu_sel_of(IR);
            Bus1_Sel = w_use_b ? BUS1_B : BUS1_PC;
            Bus2_Sel = BUS2_ALU;
            A_Load   = ~w_use_b;
            B_Load   = w_use_b;
            CCR_Load = 1'b1;
          end
          CLS_BRANCH: begin
            if (r_take) begin
              Bus2_Sel = BUS2_BUS1;
              MAR_Load = 1'b1;
            end else begin
              PC_Inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_E5: begin
        if (w_class != CLS_BRANCH) PC_Inc = 1'b1;
      end
      S_E6: begin
        Bus2_Sel = BUS2_MEM;
        case (w_class)
          CLS_LD_IMM: begin
            A_Load = ~w_use_b;
            B_Load = w_use_b;
          end
          CLS_LD_DIR, CLS_STORE: MAR_Load = 1'b1;
          CLS_BRANCH: PC_Load = 1'b1;
          default: ;
        endcase
      end
      S_E7: begin
        if (w_class == CLS_STORE) begin
          Bus1_Sel = w_use_b ? BUS1_B : BUS1_A;
          write    = 1'b1;
        end else begin
          Bus2_Sel = BUS2_MEM;
          A_Load   = ~w_use_b;
          B_Load   = w_use_b;
        end
      end
      default: ;
    endcase
  end

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  assign Halted = (r_state == S_HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a per-instruction micro-op model
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IR = 8'h00;
  logic [3:0] CCR_Result = 4'h0;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load;
  logic [2:0] ALU_Sel;
  logic       CCR_Load;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, Halted;

  control_unit #(.RST_CYCLES(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .IR_Load    (IR_Load),
    .MAR_Load   (MAR_Load),
    .PC_Load    (PC_Load),
    .PC_Inc     (PC_Inc),
    .A_Load     (A_Load),
    .B_Load     (B_Load),
    .ALU_Sel    (ALU_Sel),
    .CCR_Load   (CCR_Load),
    .Bus1_Sel   (Bus1_Sel),
    .Bus2_Sel   (Bus2_Sel),
    .write      (write),
    .Halted     (Halted)
  );

  always #5 clock = ~clock;

  logic [15:0] w_obs;
  assign w_obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
                  ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write, Halted};

  localparam logic [15:0] M_IRL  = 16'h8000;
  localparam logic [15:0] M_MAR  = 16'h4000;
  localparam logic [15:0] M_PCL  = 16'h2000;
  localparam logic [15:0] M_PCI  = 16'h1000;
  localparam logic [15:0] M_AL   = 16'h0800;
  localparam logic [15:0] M_BL   = 16'h0400;
  localparam logic [15:0] M_CCRL = 16'h0040;
  localparam logic [15:0] M_WR   = 16'h0002;
  localparam logic [15:0] M_HALT = 16'h0001;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  known [25] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                              8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B,
                              8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

  function automatic logic [15:0] f_alu(input logic [2:0] s);
    return {6'b0, s, 7'b0};
  endfunction
  function automatic logic [15:0] f_b1(input logic [1:0] s);
    return {10'b0, s, 4'b0};
  endfunction
  function automatic logic [15:0] f_b2(input logic [1:0] s);
    return {12'b0, s, 2'b0};
  endfunction

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control word per cycle from F0 to the last execute cycle
  task automatic build_expected(input logic [7:0] op, input logic [3:0] ccr);
    logic [15:0] pc_to_mar, mem, dst;
    logic [2:0]  sel;
    int          idx;
    logic        take;
    pc_to_mar = M_MAR | f_b2(2'd1);
    mem       = f_b2(2'd2);
    exp_q.delete();
    exp_q.push_back(pc_to_mar);
    exp_q.push_back(M_PCI);
    exp_q.push_back(mem | M_IRL);
    exp_q.push_back(16'h0000);
    if (op == 8'h86 || op == 8'h88) begin
      dst = (op == 8'h86) ? M_AL : M_BL;
      exp_q.push_back(pc_to_mar);
      exp_q.push_back(M_PCI);
      exp_q.push_back(mem | dst);
    end else if (op == 8'h87 || op == 8'h89) begin
      dst = (op == 8'h87) ? M_AL : M_BL;
      exp_q.push_back(pc_to_mar);
      exp_q.push_back(M_PCI);
      exp_q.push_back(mem | M_MAR);
      exp_q.push_back(mem | dst);
    end else if (op == 8'h96 || op == 8'h97) begin
      exp_q.push_back(pc_to_mar);
      exp_q.push_back(M_PCI);
      exp_q.push_back(mem | M_MAR);
      exp_q.push_back(f_b1((op == 8'h96) ? 2'd1 : 2'd2) | M_WR);
    end else if (op >= 8'h42 && op <= 8'h4B) begin
      case (op)
        8'h42: sel = 3'b000;
        8'h43: sel = 3'b010;
        8'h44: sel = 3'b100;
        8'h45: sel = 3'b101;
        8'h46, 8'h47: sel = 3'b001;
        8'h48, 8'h49: sel = 3'b011;
        8'h4A: sel = 3'b110;
        default: sel = 3'b111;
      endcase
      if (op == 8'h47 || op == 8'h49) exp_q.push_back(f_alu(sel) | f_b1(2'd2) | M_BL | M_CCRL);
      else                            exp_q.push_back(f_alu(sel) | M_AL | M_CCRL);
    end else if (op >= 8'h20 && op <= 8'h28) begin
      if (op == 8'h20) take = 1'b1;
      else begin
        idx  = int'(op - 8'h21);
        take = ccr[3 - idx / 2] ^ idx[0];
      end
      if (take) begin
        exp_q.push_back(pc_to_mar);
        exp_q.push_back(16'h0000);
        exp_q.push_back(mem | M_PCL);
      end else begin
        exp_q.push_back(M_PCI);
      end
    end else begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      repeat (8) exp_q.push_back(M_HALT);
`endif
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr);
    build_expected(op, ccr);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clock);
      #1;
      if (k == 3) begin
        IR         = op;
        CCR_Result = ccr;
      end else begin
        CCR_Result = 4'($urandom);
      end
      @(negedge clock);
      check_vec($sformatf("op%02h_cyc%0d", op, k), w_obs, exp_q[k]);
    end
  endtask

  // Called just after a negedge sample: async assert, then one S_RST cycle
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_vec({tag, "_async"}, w_obs, 16'h0000);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_vec({tag, "_s_rst"}, w_obs, 16'h0000);
  endtask

  initial begin
    logic [7:0] op;
    @(negedge clock);
    check_vec("in_reset", w_obs, 16'h0000);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_vec("s_rst", w_obs, 16'h0000);

    run_instr(8'h86, 4'h0);
    run_instr(8'h96, 4'h0);
    run_instr(8'h43, 4'h0);
    run_instr(8'h49, 4'h0);
    run_instr(8'h23, 4'b0100);
    run_instr(8'h23, 4'b0000);
    run_instr(8'h87, 4'hF);
    run_instr(8'h89, 4'h0);
    run_instr(8'h97, 4'h0);
    run_instr(8'h88, 4'h0);
    run_instr(8'h47, 4'h0);
    run_instr(8'h4B, 4'h0);
    run_instr(8'h20, 4'h0);
    run_instr(8'h28, 4'b0001);
    run_instr(8'hFF, 4'h0);
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    do_reset("halt_exit");
`endif

    repeat (80) begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      op = known[$urandom_range(0, 24)];
`else
      if ($urandom_range(0, 4) == 0) op = 8'($urandom);
      else                            op = known[$urandom_range(0, 24)];
`endif
      run_instr(op, 4'($urandom));
    end

    run_instr(8'h96, 4'h0);
    do_reset("sta_abort");
    run_instr(8'h86, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle Moore FSM for the 8-bit CPU. Sequences fetch, decode and execute.
- Drives every load, select and write strobe in the data path, including ALU_Sel for the ALU.
- Consumes the registered NZVC condition codes (CCR_Result) to resolve conditional branches.
- Sits beside the data path inside the cpu wrapper.

Parameters:
- RST_CYCLES, 1, number of idle S_RST cycles after reset release before the first fetch (range 1..4).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  8  current opcode from the instruction register.
- CCR_Result  in  4  registered flags {N,Z,V,C}.
- IR_Load  out  1  load IR from Bus2.
- MAR_Load  out  1  load MAR from Bus2.
- PC_Load  out  1  load PC from Bus2.
- PC_Inc  out  1  PC <= PC+1.
- A_Load  out  1  load register A from Bus2.
- B_Load  out  1  load register B from Bus2.
- ALU_Sel  out  3  ALU operation code.
- CCR_Load  out  1  capture ALU NZVC into CCR.
- Bus1_Sel  out  2  00=PC, 01=A, 10=B.
- Bus2_Sel  out  2  00=ALU result, 01=Bus1, 10=from_memory.
- write  out  1  memory write strobe (address=MAR, data=Bus1).
- Halted  out  1  trap indicator; constant 0 unless ILLEGAL_TRAP_EN.

Behaviour:
- Async reset low: state <= S_RST and the reset-cycle counter clears.
- In S_RST all outputs are 0; the FSM stays there RST_CYCLES cycles, then goes to F0.
- Outputs are a pure function of state and IR; no glitch-sensitive Mealy paths on CCR_Result.
- Any output not listed for a state is 0.
- A reset asserted mid-instruction aborts it immediately; there is no partial write, because write is low in S_RST.
- Fetch sequence:
  - F0: Bus1=PC, Bus2=Bus1, MAR_Load.
  - F1: PC_Inc.
  - F2: Bus2=mem, IR_Load.
  - D3: no outputs; dispatch on IR.
- Immediate load, LDA_IMM 0x86 / LDB_IMM 0x88:
  - E4: MAR<=PC. E5: PC_Inc. E6: Bus2=mem, A_Load or B_Load.
  - Then F0. Total 7 cycles.
- Direct load, LDA_DIR 0x87 / LDB_DIR 0x89:
  - E4, E5 as above. E6: Bus2=mem, MAR_Load. E7: Bus2=mem, A_Load or B_Load. Total 8 cycles.
- Store, STA_DIR 0x96 / STB_DIR 0x97:
  - E4..E6 as direct load. E7: Bus1=A or B, write=1. Total 8 cycles.
- ALU ops, result into A except INCB/DECB into B. Opcode -> ALU_Sel:
  - ADD 0x42 -> 000. SUB 0x43 -> 010. AND 0x44 -> 100. OR 0x45 -> 101. XOR 0x4A -> 110. NOTA 0x4B -> 111.
  - INCA 0x46 / INCB 0x47 -> 001.
  - DECA 0x48 / DECB 0x49 -> 011.
  - E4: ALU_Sel set, Bus1=B (Bus1=B for INCB/DECB; otherwise the ALU takes A, B directly), Bus2=ALU result, destination load, CCR_Load. Total 5 cycles.
- Branches:
  - Opcodes: BRA 0x20, BMI 0x21 (N), BPL 0x22 (!N), BEQ 0x23 (Z), BNE 0x24 (!Z), BVS 0x25 (V), BVC 0x26 (!V), BCS 0x27 (C), BCC 0x28 (!C).
  - Taken: E4: MAR<=PC. E5: idle (memory latency). E6: Bus2=mem, PC_Load. Total 7 cycles.
  - Not taken: E4: PC_Inc (skip operand). Total 5 cycles.
  - The condition is sampled from CCR_Result in D3 and latched; later CCR changes do not affect the decision.
- PC wrap: 0xFF+1 -> 0x00 is handled by the PC. The FSM is unaffected.
- Unknown opcode: without ILLEGAL_TRAP_EN, D3 -> F0 (NOP, 4 cycles).

Optional Feature:
- Macro: CONTROL_UNIT_ILLEGAL_TRAP_EN.
- When defined: an unknown opcode goes D3 -> S_HALT.
  - Halted=1 and all other outputs are 0.
  - Only reset exits S_HALT.
- When undefined: S_HALT does not exist and Halted is tied to 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants;
  - the state enumeration;
  - ALU_Sel codes (shared with the ALU);
  - Bus1/Bus2 select encodings;
  - the NZVC bit indices N=3, Z=2, V=1, C=0.
- One natural sub-module: branch_cond. It is combinational, maps (IR, CCR_Result) -> take_branch, and is unit-testable on its own.

Test Plan:
- Reset low for 3 cycles, release, RST_CYCLES=1 -> all outputs 0 through S_RST; MAR_Load=1 with Bus1_Sel=00 on the 2nd cycle after release.
- IR=0x86 -> outputs per cycle F0..E6; A_Load=1 with Bus2_Sel=10 in cycle 7 exactly, then back to F0.
- IR=0x96 -> write=1 with Bus1_Sel=01 in cycle 8 only; write=0 in every other cycle.
- IR=0x43 -> E4: ALU_Sel=010, A_Load=1, CCR_Load=1, Bus2_Sel=00; IR=0x49 -> B_Load=1, ALU_Sel=011.
- IR=0x23 with CCR_Result=0100 -> PC_Load in E6 (7 cycles). With CCR_Result=0000 -> PC_Inc in E4, back to F0 after 5 cycles. CCR toggled during E4/E5 does not change the outcome.
- IR=0xFF -> with the macro, Halted=1 held until reset; without it, F0 follows D3. Reset asserted in E7 of STA -> write=0 immediately.
